joltage_select_k: RTL and testbench
===================================

# joltage_select_k

- Streaming ASCII line processor, the parametrised generalisation of the two-digit joltage selector.
- For each newline-terminated line of decimal digits, it picks exactly NUM_DIGITS digits, keeping their original order, to form the largest possible number.
- It adds that number into a running total.
- It sits behind the byte source, uses the same four-phase valid/ack handshake and error/clear scheme, and the total goes to the host.

## Interface
- NUM_DIGITS, default 12: digits selected per line K; legal range 1..18.
- RESULT_W, default 64: accumulator width.
- VAL_W, derived localparam, not overridable: bits to hold 10^K-1 (40 for K=12).
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- data_in  in  8: ASCII byte.
- data_valid  in  1: byte present; held until data_ack seen, then dropped.
- data_ack  out  1: byte consumed; held until data_valid low.
- result  out  RESULT_W: running sum of line values, modulo 2^RESULT_W.
- result_ready  out  1: high while the post-line ack is held.
- line_count  out  16: accepted lines since reset, wraps.
- overflow  out  1: sticky; set when any accumulation carries out of RESULT_W.
- data_error  out  1: high exactly while in S_ERROR.
- error_clear  in  1: leave S_ERROR.

## Operation
- Per line it keeps best[1..K], each VAL_W bits: best[j] is the largest j-digit subsequence of the prefix so far, with best[0]=0.
- It keeps digit counter n, saturating at K.
- On digit d, for j = K down to 1, one j per cycle, with n the value before this digit:
  - n >= j: best[j] = max(best[j], best[j-1]*10+d).
  - n == j-1: best[j] = best[j-1]*10+d.
  - otherwise: best[j] is unchanged.
  - Descending j makes the in-place update use the old best[j-1].
- On newline with n == K: result += best[K], zero-extended; line_count++; then best[], n and j are cleared.
- States:
  - S_EXPECT_DIGIT: digit -> S_UPDATE; newline or other -> S_ERROR.
  - S_EXPECT_DIGIT_OR_EOL:
    - digit -> S_UPDATE.
    - newline with n==K -> S_ACCUM.
    - newline with n<K -> S_ERROR.
    - other -> S_ERROR.
  - S_UPDATE: K cycles, j from K down to 1; -> S_ACK.
  - S_ACK: data_ack=1; when data_valid goes low -> S_EXPECT_DIGIT_OR_EOL.
  - S_ACCUM: 1 cycle; result, overflow and line_count update; -> S_RESULT_READY.
  - S_RESULT_READY: data_ack=1, result_ready=1; clears line state; when data_valid goes low -> S_EXPECT_DIGIT.
  - S_ERROR:
    - data_ack=0; line state cleared.
    - result, line_count and overflow are preserved.
    - error_clear -> S_EXPECT_DIGIT.
    - If data_valid is still high on exit, the byte is re-evaluated.
- Illegal state encoding -> S_EXPECT_DIGIT.

## Timing
- Reset values:
  - State S_EXPECT_DIGIT.
  - data_ack, result_ready, data_error, overflow = 0.
  - result, line_count = 0.
  - best[] and n = 0.
- Input sampling: data_in is sampled only in the cycle in which an EXPECT state sees data_valid high.
- The source must hold data_in stable until data_ack.
- Digit latency: sample cycle, then K S_UPDATE cycles, then data_ack rises in the 1st S_ACK cycle.
- Newline latency: sample cycle, then S_ACCUM, then data_ack and result_ready rise, with result already updated.
- data_ack falls in the cycle after data_valid is seen low.
- data_error: registered; rises on the first S_ERROR cycle and falls on the cycle of exit.
- error_clear is ignored outside S_ERROR.
- Reset mid-line or mid-update: immediate return to the reset values; the partial line is lost.
- Arithmetic:
  - best[j-1]*10+d is computed at VAL_W and cannot overflow, since it is below 10^K.
  - The accumulator is an unsigned RESULT_W add; the carry-out ORs into overflow.

## Structure
- Package joltage_pkg:
  - state_t enum.
  - ASCII_0, ASCII_9 and ASCII_NEWLINE constants.
  - Function dec_bits(k) = $clog2(10**k), used for VAL_W.
- Sub-module joltage_best_dp:
  - Holds the best[] register file, n and the j counter.
  - Ports: start, digit, clear, busy/done, best_k.
- The top level holds the FSM, handshake, accumulator and counters.

## Test plan
- Four example lines with K=12: "987654321111111", "811111111111119", "234234234234278", "818181911112111".
  - Required line values: 987654321111, 811111111119, 434234234278, 888911112111.
  - Required final result: 3121910778619; line_count=4.
- Same four lines with K=2 -> line values 98, 89, 78, 92; result=357.
- K=12, "12345\n":
  - data_error rises on the newline; result and line_count are unchanged.
  - After error_clear, the line "999999999999\n" gives result = prior + 999999999999.
- "1a" and a bare "\n":
  - Each drives S_ERROR with data_ack low.
  - data_error is held until error_clear.
  - The block then accepts the next line normally.
- RESULT_W=8, K=2, three lines "99" -> result 99, then 198, then 41; overflow=1 after the third line and stays set.
- Handshake and reset checks:
  - Hold data_valid high for 5 cycles past data_ack -> data_ack stays high and the byte is processed once.
  - Per-digit ack latency is exactly K+2 cycles after data_valid rises.
  - Assert rst_n low mid-S_UPDATE -> all outputs return to their reset values.

Source files
------------

// File: rtl/joltage_pkg.sv
// Shared types and constants for the streaming K-digit joltage selector.
package joltage_pkg;

    typedef enum logic [2:0] {
        S_EXPECT_DIGIT,
        S_EXPECT_DIGIT_OR_EOL,
        S_UPDATE,
        S_ACK,
        S_ACCUM,
        S_RESULT_READY,
        S_ERROR
    } state_t;

    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    // Bits needed to hold 10^k - 1.
    function automatic int unsigned dec_bits(input int unsigned k);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < k; i++) begin
            p = p * 64'd10;
        end
        return 32'($clog2(p));
    endfunction

endpackage

// File: rtl/joltage_best_dp.sv
// Per-line DP table: best[j] is the largest j-digit subsequence seen so far.
// One j per cycle, descending, so the in-place update reads the old best[j-1].
module joltage_best_dp
    import joltage_pkg::*;
#(
    parameter int unsigned K     = 12,
    parameter int unsigned VAL_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       digit,
    input  logic             clear,
    output logic             done_c,
    output logic             full_c,
    output logic [VAL_W-1:0] best_k
);

    localparam int unsigned JW = $clog2(K + 1);

    logic [VAL_W-1:0] best [0:K];
    logic [JW-1:0]    n;
    logic [JW-1:0]    j;
    logic [JW-1:0]    jm1;
    logic [3:0]       dig;
    logic             busy;
    logic [VAL_W-1:0] cand;

    assign jm1    = j - JW'(1);
    assign cand   = (best[jm1] * VAL_W'(10)) + VAL_W'(dig);
    assign done_c = busy && (j == JW'(1));
    assign full_c = (n == JW'(K));
    assign best_k = best[K];

    // best[0] is never written after clear, so it stays the zero base case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best <= '{default: '0};
            n    <= '0;
            j    <= '0;
            dig  <= '0;
            busy <= 1'b0;
        end else if (clear) begin
            best <= '{default: '0};
            n    <= '0;
            j    <= '0;
            dig  <= '0;
            busy <= 1'b0;
        end else if (busy) begin
            if (n >= j) begin
                if (cand > best[j]) begin
                    best[j] <= cand;
                end
            end else if (n == jm1) begin
                best[j] <= cand;
            end
            if (j == JW'(1)) begin
                busy <= 1'b0;
                if (!full_c) begin
                    n <= n + JW'(1);
                end
            end
            j <= jm1;
        end else if (start) begin
            busy <= 1'b1;
            j    <= JW'(K);
            dig  <= digit;
        end
    end

endmodule

// File: rtl/joltage_select_k.sv
// Streaming ASCII line processor: per line, picks the largest ordered
// NUM_DIGITS-digit subsequence and adds it into a running total.
module joltage_select_k
    import joltage_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 12,
    parameter int unsigned RESULT_W   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          data_in,
    input  logic                data_valid,
    output logic                data_ack,
    output logic [RESULT_W-1:0] result,
    output logic                result_ready,
    output logic [15:0]         line_count,
    output logic                overflow,
    output logic                data_error,
    input  logic                error_clear
);

    localparam int unsigned VAL_W = dec_bits(NUM_DIGITS);
    localparam int unsigned SUM_W = RESULT_W + 1;

    state_t           state;
    state_t           state_next;
    logic             is_digit_c;
    logic             is_eol_c;
    logic [3:0]       digit_c;
    logic             start_c;
    logic             clear_c;
    logic             accum_c;
    logic             done_c;
    logic             full_c;
    logic [VAL_W-1:0] best_k;
    logic [SUM_W-1:0] sum_c;

    assign is_digit_c = (data_in >= ASCII_0) && (data_in <= ASCII_9);
    assign is_eol_c   = (data_in == ASCII_NEWLINE);
    assign digit_c    = 4'(data_in - ASCII_0);
    assign sum_c      = {1'b0, result} + SUM_W'(best_k);

    joltage_best_dp #(
        .K     (NUM_DIGITS),
        .VAL_W (VAL_W)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .digit  (digit_c),
        .clear  (clear_c),
        .done_c (done_c),
        .full_c (full_c),
        .best_k (best_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EXPECT_DIGIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        clear_c    = 1'b0;
        accum_c    = 1'b0;
        case (state)
            S_EXPECT_DIGIT: begin
                if (data_valid) begin
                    if (is_digit_c) begin
                        state_next = S_UPDATE;
                        start_c    = 1'b1;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_EXPECT_DIGIT_OR_EOL: begin
                if (data_valid) begin
                    if (is_digit_c) begin
                        state_next = S_UPDATE;
                        start_c    = 1'b1;
                    end else if (is_eol_c && full_c) begin
                        state_next = S_ACCUM;
                    end else begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_UPDATE: begin
                if (done_c) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!data_valid) begin
                    state_next = S_EXPECT_DIGIT_OR_EOL;
                end
            end
            S_ACCUM: begin
                accum_c    = 1'b1;
                state_next = S_RESULT_READY;
            end
            S_RESULT_READY: begin
                clear_c = 1'b1;
                if (!data_valid) begin
                    state_next = S_EXPECT_DIGIT;
                end
            end
            S_ERROR: begin
                clear_c = 1'b1;
                if (error_clear) begin
                    state_next = S_EXPECT_DIGIT;
                end
            end
            default: state_next = S_EXPECT_DIGIT;
        endcase
    end

    // Status flags follow the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_ack     <= 1'b0;
            result_ready <= 1'b0;
            data_error   <= 1'b0;
        end else begin
            data_ack     <= (state_next == S_ACK) || (state_next == S_RESULT_READY);
            result_ready <= (state_next == S_RESULT_READY);
            data_error   <= (state_next == S_ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            line_count <= '0;
            overflow   <= 1'b0;
        end else if (accum_c) begin
            result     <= sum_c[RESULT_W-1:0];
            line_count <= line_count + 16'd1;
            overflow   <= overflow | sum_c[RESULT_W];
        end
    end

endmodule

// File: tb/tb_joltage_select_k.sv
// Bench for joltage_select_k: three instances (K=12/64b, K=2/64b, K=2/8b)
// checked against a greedy window-max reference for the line value.
module tb_joltage_select_k;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din [3];
    logic [2:0]  valid;
    logic [2:0]  eclr;
    logic [2:0]  ack;
    logic [2:0]  ready;
    logic [2:0]  err;
    logic [2:0]  ovf;
    logic [63:0] res [3];
    logic [7:0]  res8;
    logic [15:0] lc [3];

    int n_cmp  = 0;
    int n_fail = 0;

    longint unsigned exp_res [3];
    logic [15:0]     exp_lc [3];
    logic            exp_ovf [3];

    always #5 clk = ~clk;

    assign res[2] = 64'(res8);

    joltage_select_k #(.NUM_DIGITS(12), .RESULT_W(64)) u_k12 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_valid(valid[0]),
        .data_ack(ack[0]), .result(res[0]), .result_ready(ready[0]),
        .line_count(lc[0]), .overflow(ovf[0]), .data_error(err[0]),
        .error_clear(eclr[0])
    );

    joltage_select_k #(.NUM_DIGITS(2), .RESULT_W(64)) u_k2 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_valid(valid[1]),
        .data_ack(ack[1]), .result(res[1]), .result_ready(ready[1]),
        .line_count(lc[1]), .overflow(ovf[1]), .data_error(err[1]),
        .error_clear(eclr[1])
    );

    joltage_select_k #(.NUM_DIGITS(2), .RESULT_W(8)) u_r8 (
        .clk(clk), .rst_n(rst_n), .data_in(din[2]), .data_valid(valid[2]),
        .data_ack(ack[2]), .result(res8), .result_ready(ready[2]),
        .line_count(lc[2]), .overflow(ovf[2]), .data_error(err[2]),
        .error_clear(eclr[2])
    );

    function automatic int kof(input int i);
        return (i == 0) ? 12 : 2;
    endfunction

    function automatic bq_t str_q(input string s);
        bq_t q;
        q = {};
        for (int k = 0; k < s.len(); k++) q.push_back(8'(s[k]));
        return q;
    endfunction

    // Greedy: the p-th chosen digit is the first maximum in the window that
    // still leaves enough digits after it for the remaining picks.
    function automatic longint unsigned model_value(input bq_t q, input int k);
        longint unsigned v;
        int start;
        int bi;
        v = 64'd0;
        start = 0;
        for (int p = 0; p < k; p++) begin
            bi = start;
            for (int x = start; x <= q.size() - k + p; x++) begin
                if (q[x] > q[bi]) bi = x;
            end
            v = v * 64'd10 + 64'(q[bi] - 8'h30);
            start = bi + 1;
        end
        return v;
    endfunction

    function automatic void model_accept(input int i, input bq_t q);
        longint unsigned s;
        s = exp_res[i] + model_value(q, kof(i));
        if (i == 2) begin
            if (s > 64'd255) exp_ovf[i] = 1'b1;
            s = s & 64'd255;
        end
        exp_res[i] = s;
        exp_lc[i]  = exp_lc[i] + 16'd1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            exp_res[i] = 64'd0;
            exp_lc[i]  = 16'd0;
            exp_ovf[i] = 1'b0;
        end
    endfunction

    // st: 0 = acked, 1 = entered error, 2 = timed out
    task automatic send_byte(input int i, input logic [7:0] b, output int st,
                             output logic rdy, output logic [63:0] r);
        din[i]   = b;
        valid[i] = 1'b1;
        st  = 2;
        rdy = 1'b0;
        r   = 64'd0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (ack[i]) begin st = 0; rdy = ready[i]; r = res[i]; break; end
            if (err[i]) begin st = 1; r = res[i]; break; end
        end
        valid[i] = 1'b0;
        if (st == 2) begin
            n_cmp++; n_fail++;
            $display("FAIL handshake_timeout inst=%0d byte=%h: no ack or error within 200 cycles", i, b);
        end else if (st == 0) begin
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (!ack[i]) break;
            end
            if (ack[i]) begin
                n_cmp++; n_fail++;
                $display("FAIL ack_release inst=%0d: data_ack still 1, required 0", i);
            end
        end
    endtask

    task automatic send_line(input int i, input bq_t q, output int st,
                             output logic rdy, output logic [63:0] r);
        foreach (q[k]) begin
            send_byte(i, q[k], st, rdy, r);
            if (st != 0) return;
        end
        send_byte(i, 8'h0A, st, rdy, r);
    endtask

    task automatic pulse_clear(input int i);
        eclr[i] = 1'b1;
        @(posedge clk); #1;
        eclr[i] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({ack[i], ready[i], err[i], ovf[i]} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_flags inst=%0d: ack/rdy/err/ovf=%b required 0000", i,
                         {ack[i], ready[i], err[i], ovf[i]});
            end
            n_cmp++;
            if (res[i] !== 64'd0 || lc[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_counts inst=%0d: result=%0d lines=%0d required 0/0", i, res[i], lc[i]);
            end
        end
    endtask

    task automatic test_examples(input int i);
        string lines [4];
        longint unsigned cum [4];
        bq_t q;
        int st;
        logic rdy;
        logic [63:0] r;
        lines = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};
        if (i == 0) cum = '{64'd987654321111, 64'd1798765432230, 64'd2232999666508, 64'd3121910778619};
        else        cum = '{64'd98, 64'd187, 64'd265, 64'd357};
        for (int k = 0; k < 4; k++) begin
            q = str_q(lines[k]);
            model_accept(i, q);
            send_line(i, q, st, rdy, r);
            n_cmp++;
            if (st !== 0 || rdy !== 1'b1 || r !== cum[k]) begin
                n_fail++;
                $display("FAIL example inst=%0d line=%0d: st=%0d rdy=%b result=%0d required 0/1/%0d",
                         i, k, st, rdy, r, cum[k]);
            end
        end
        n_cmp++;
        if (lc[i] !== 16'd4) begin
            n_fail++;
            $display("FAIL example_lines inst=%0d: line_count=%0d required 4", i, lc[i]);
        end
    endtask

    task automatic test_short_line_error();
        int st;
        logic rdy;
        logic [63:0] r;
        bq_t q;
        send_line(0, str_q("12345"), st, rdy, r);
        n_cmp++;
        if (st !== 1 || err[0] !== 1'b1 || ack[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_line_error: st=%0d err=%b ack=%b required 1/1/0", st, err[0], ack[0]);
        end
        n_cmp++;
        if (res[0] !== exp_res[0] || lc[0] !== exp_lc[0]) begin
            n_fail++;
            $display("FAIL short_line_keep: result=%0d lines=%0d required %0d/%0d",
                     res[0], lc[0], exp_res[0], exp_lc[0]);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL error_hold: data_error=%b required 1", err[0]);
        end
        pulse_clear(0);
        n_cmp++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL error_exit: data_error=%b required 0", err[0]);
        end
        q = str_q("999999999999");
        model_accept(0, q);
        send_line(0, q, st, rdy, r);
        n_cmp++;
        if (st !== 0 || r !== 64'd3121910778619 + 64'd999999999999) begin
            n_fail++;
            $display("FAIL after_clear_line: st=%0d result=%0d required 0/%0d",
                     st, r, 64'd3121910778619 + 64'd999999999999);
        end
    endtask

    task automatic test_bad_char();
        int st;
        logic rdy;
        logic [63:0] r;
        bq_t q;
        send_line(1, str_q("1a"), st, rdy, r);
        n_cmp++;
        if (st !== 1 || err[1] !== 1'b1 || ack[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_char: st=%0d err=%b ack=%b required 1/1/0", st, err[1], ack[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (err[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_char_hold: data_error=%b required 1", err[1]);
        end
        pulse_clear(1);
        q = {};
        send_line(1, q, st, rdy, r);
        n_cmp++;
        if (st !== 1 || err[1] !== 1'b1 || ack[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bare_newline: st=%0d err=%b ack=%b required 1/1/0", st, err[1], ack[1]);
        end
        n_cmp++;
        if (res[1] !== exp_res[1] || lc[1] !== exp_lc[1]) begin
            n_fail++;
            $display("FAIL bare_newline_keep: result=%0d lines=%0d required %0d/%0d",
                     res[1], lc[1], exp_res[1], exp_lc[1]);
        end
        pulse_clear(1);
        q = str_q("57");
        model_accept(1, q);
        send_line(1, q, st, rdy, r);
        n_cmp++;
        if (st !== 0 || rdy !== 1'b1 || r !== exp_res[1] || lc[1] !== exp_lc[1]) begin
            n_fail++;
            $display("FAIL recover_line: st=%0d rdy=%b result=%0d lines=%0d required 0/1/%0d/%0d",
                     st, rdy, r, lc[1], exp_res[1], exp_lc[1]);
        end
    endtask

    task automatic test_overflow();
        string lines [4];
        logic [63:0] want_r [4];
        logic want_o [4];
        int st;
        logic rdy;
        logic [63:0] r;
        lines  = '{"99", "99", "99", "10"};
        want_r = '{64'd99, 64'd198, 64'd41, 64'd51};
        want_o = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            model_accept(2, str_q(lines[k]));
            send_line(2, str_q(lines[k]), st, rdy, r);
            n_cmp++;
            if (st !== 0 || r !== want_r[k] || r !== exp_res[2]) begin
                n_fail++;
                $display("FAIL overflow_result line=%0d: result=%0d required %0d", k, r, want_r[k]);
            end
            n_cmp++;
            if (ovf[2] !== want_o[k] || ovf[2] !== exp_ovf[2]) begin
                n_fail++;
                $display("FAIL overflow_flag line=%0d: overflow=%b required %b", k, ovf[2], want_o[k]);
            end
        end
    endtask

    // Ack is seen k+1 edges after the sample cycle begins, i.e. in cycle k+2.
    task automatic test_handshake(input int i);
        int k;
        int cyc;
        logic held;
        bq_t rest;
        bq_t full;
        int st;
        logic rdy;
        logic [63:0] r;
        k = kof(i);
        din[i]   = 8'h35;
        valid[i] = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (ack[i]) break;
        end
        n_cmp++;
        if (cyc !== k + 1) begin
            n_fail++;
            $display("FAIL ack_latency inst=%0d: ack after %0d edges required %0d", i, cyc, k + 1);
        end
        held = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!ack[i]) held = 1'b0;
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_hold inst=%0d: data_ack dropped while valid held, required 1", i);
        end
        valid[i] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ack[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_fall inst=%0d: data_ack=%b required 0", i, ack[i]);
        end
        rest = (i == 0) ? str_q("12345678901") : str_q("3");
        full = rest;
        full.push_front(8'h35);
        model_accept(i, full);
        send_line(i, rest, st, rdy, r);
        n_cmp++;
        if (st !== 0 || rdy !== 1'b1 || r !== exp_res[i]) begin
            n_fail++;
            $display("FAIL held_byte_once inst=%0d: st=%0d rdy=%b result=%0d required 0/1/%0d",
                     i, st, rdy, r, exp_res[i]);
        end
    endtask

    task automatic test_random();
        bq_t q;
        int len;
        int k;
        int st;
        logic rdy;
        logic [63:0] r;
        for (int i = 0; i < 2; i++) begin
            k = kof(i);
            for (int n = 0; n < 14; n++) begin
                q = {};
                if (i == 0 && $urandom_range(0, 4) == 0) begin
                    len = int'($urandom_range(1, 11));
                    for (int d = 0; d < len; d++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                    send_line(i, q, st, rdy, r);
                    n_cmp++;
                    if (st !== 1 || err[i] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL random_short inst=%0d len=%0d: st=%0d err=%b required 1/1", i, len, st, err[i]);
                    end
                    pulse_clear(i);
                end else begin
                    len = k + int'($urandom_range(0, 8));
                    for (int d = 0; d < len; d++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                    model_accept(i, q);
                    send_line(i, q, st, rdy, r);
                    n_cmp++;
                    if (st !== 0 || rdy !== 1'b1 || r !== exp_res[i]) begin
                        n_fail++;
                        $display("FAIL random_line inst=%0d n=%0d: st=%0d rdy=%b result=%0d required 0/1/%0d",
                                 i, n, st, rdy, r, exp_res[i]);
                    end
                end
            end
            n_cmp++;
            if (lc[i] !== exp_lc[i]) begin
                n_fail++;
                $display("FAIL random_lines inst=%0d: line_count=%0d required %0d", i, lc[i], exp_lc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_update();
        bq_t q;
        int st;
        logic rdy;
        logic [63:0] r;
        din[0]   = 8'h35;
        valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({ack[i], ready[i], err[i], ovf[i]} !== 4'b0000 || res[i] !== 64'd0 || lc[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL mid_reset inst=%0d: flags=%b result=%0d lines=%0d required 0000/0/0",
                         i, {ack[i], ready[i], err[i], ovf[i]}, res[i], lc[i]);
            end
        end
        valid[0] = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        q = str_q("111111111111");
        model_accept(0, q);
        send_line(0, q, st, rdy, r);
        n_cmp++;
        if (st !== 0 || r !== 64'd111111111111 || lc[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL post_reset_line: st=%0d result=%0d lines=%0d required 0/111111111111/1", st, r, lc[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 3'b000;
        eclr  = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_examples(0);
        test_examples(1);
        test_short_line_error();
        test_bad_char();
        test_overflow();
        test_handshake(0);
        test_handshake(1);
        test_random();
        test_reset_mid_update();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
